lancer_de: RTL and testbench
============================

# lancer_de

Dice-roll engine for the tabletop dice roller. It consumes the die bounds (`min_de`, `max_de`) published by the die-type selector and produces the rolled value. On a roll request it runs a visible "rolling" phase, draws a pseudo-random sample and reduces it into `[min_de, max_de]`. It then converts the result to BCD and drives three 7-segment digits with the result, while the selector keeps the die-type display.

## Interface
Parameters:
- `ROLL_CYCLES`, default 50_000_000: length of the rolling phase in clock cycles (≥1).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value (must be nonzero).

Ports (all synchronous to `clk`):
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `lancer` in 1: roll button, already debounced; level, rising edge detected internally.
- `min_de` in 7: lower bound, unsigned, 1..100.
- `max_de` in 7: upper bound, unsigned, 1..100.
- `resultat` out 7: last rolled value, unsigned.
- `valide` out 1: `resultat` holds a completed roll.
- `occupe` out 1: roll in progress.
- `erreur` out 1: last request had `min_de > max_de`.
- `hex100`, `hex10`, `hex1` out 7 each: segments `{g,f,e,d,c,b,a}`, active-low.

## Operation
- 16-bit Fibonacci LFSR, taps 16,14,13,11. Advances every cycle in every state, so roll timing adds entropy. Never reaches 0.
- FSM states: IDLE → ROLL → REDUCE → CONV → DONE. DONE behaves like IDLE but with `valide`=1.
- IDLE/DONE, rising edge on `lancer`:
  - latch `min_de`, `max_de` and span = max−min+1 (7 bits);
  - clear `valide` and `erreur`; set `occupe`; go to ROLL.
- ROLL: count `ROLL_CYCLES` cycles. On the last cycle, capture `lfsr[7:0]` as the sample; go to REDUCE.
- REDUCE: sequential modulo.
  - Each cycle, if sample ≥ span, then sample −= span.
  - Otherwise `resultat` = min + sample; go to CONV.
  - If latched min > max: `resultat` = min, `erreur`=1, skip straight to CONV.
- CONV: double-dabble over the 7 result bits, one bit per cycle (7 cycles), into three BCD digits. Then go to DONE with `occupe`=0 and `valide`=1.
- Display:
  - DONE: show the result decimal with leading-zero blanking. `hex100` blank if hundreds=0; `hex10` blank if hundreds=0 and tens=0; `hex1` always lit.
  - IDLE after reset: all three digits blank (7'h7F).
  - ROLL/REDUCE/CONV: see Configuration.
- `lancer` edges during ROLL/REDUCE/CONV are ignored; they are not queued.
- Changes to `min_de`/`max_de` after acceptance do not affect the roll in progress.

## Timing
- Reset values:
  - `resultat`=0, `valide`=0, `occupe`=0, `erreur`=0;
  - `hex*`=7'h7F;
  - state IDLE, LFSR=`LFSR_SEED`, edge-detect register=0.
- Edge detect is registered. A `lancer` rising edge in cycle N sets `occupe` in cycle N+1.
- Latency from `occupe` rising to `valide` rising: `ROLL_CYCLES` + (⌊sample/span⌋+1) + 7 + 1 cycles.
  - Worst case is span=1, sample=255: `ROLL_CYCLES`+264.
- `resultat` and `hex*` update in the same cycle that `valide` rises.
- `resultat` remains stable until the next accepted request. It is not cleared on request; only `valide` drops.
- `rst` mid-roll: abort on the next edge; all outputs return to reset values.
- Request edge in DONE on the same cycle as `rst`: `rst` wins.

## Configuration
- Macro `LANCER_DE_ANIM_EN`.
- Defined: during ROLL/REDUCE/CONV, the three digits show `lfsr[3:0] mod 10`, `lfsr[7:4] mod 10` and `lfsr[11:8] mod 10`, refreshed every cycle (flicker animation). No leading-zero blanking.
- Undefined: during ROLL/REDUCE/CONV, all three digits show dash (7'b0111111), and the animation logic is not synthesized.
- Result display and all other behaviour are identical in both builds.

## Test plan
- Reset: assert `rst` 2 cycles → `resultat`=0, `valide`=0, `occupe`=0, `erreur`=0, all `hex*`=7'h7F.
- d6: `ROLL_CYCLES`=10, min=1, max=6, pulse `lancer`.
  - `occupe` rises 1 cycle later.
  - `valide` rises within 10+43+8 cycles.
  - `resultat` in 1..6; `hex100`/`hex10` blank; `hex1` matches `resultat`.
- d100, 1000 rolls: every `resultat` in 1..100. A result of 100 displays "100"; any value 10..99 shows `hex100` blank.
- Busy rejection: extra `lancer` edges during ROLL and REDUCE → exactly one `valide` rise; latched bounds unchanged when `max_de` changes mid-roll.
- Error path: min=8, max=4 → `erreur`=1, `resultat`=8, `valide`=1.
- Mid-roll reset: assert `rst` during ROLL → next cycle all reset values. A new request then completes normally. Display during ROLL is dashes without `LANCER_DE_ANIM_EN` and LFSR-derived digits with it.

Source files
------------

// File: rtl/lancer_de.sv
// lancer_de: dice-roll engine - LFSR draw, modulo reduction, BCD conversion, 7-segment display.
// Define LANCER_DE_ANIM_EN to show LFSR-driven flicker digits while a roll is in progress.

module lancer_de #(
    parameter int unsigned ROLL_CYCLES = 50_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lancer,
    input  logic [6:0] min_de,
    input  logic [6:0] max_de,
    output logic [6:0] resultat,
    output logic       valide,
    output logic       occupe,
    output logic       erreur,
    output logic [6:0] hex100,
    output logic [6:0] hex10,
    output logic [6:0] hex1
);

    localparam int unsigned     CntW     = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(ROLL_CYCLES - 1);
    localparam logic [6:0]      SegBlank = 7'h7F;
    localparam logic [6:0]      SegDash  = 7'b0111111;

    typedef enum logic [2:0] {StIdle, StRoll, StReduce, StConv, StDone} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              lancer_q;
    logic [6:0]        min_q, min_d;
    logic [6:0]        max_q, max_d;
    logic [6:0]        span_q, span_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        sample_q, sample_d;
    logic [2:0]        conv_cnt_q, conv_cnt_d;
    logic [6:0]        value_q, value_d;
    logic [6:0]        bin_q, bin_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [6:0]        resultat_q, resultat_d;
    logic              erreur_q, erreur_d;
    logic              rise;
    logic [11:0]       bcd_adj;

    // Segments {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

`ifdef LANCER_DE_ANIM_EN
    function automatic logic [3:0] mod10(input logic [3:0] d);
        return (d >= 4'd10) ? d - 4'd10 : d;
    endfunction
`endif

    assign rise    = lancer & ~lancer_q;
    assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= LFSR_SEED;
            lancer_q   <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            span_q     <= '0;
            cnt_q      <= '0;
            sample_q   <= '0;
            conv_cnt_q <= '0;
            value_q    <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            resultat_q <= '0;
            erreur_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            lancer_q   <= lancer;
            min_q      <= min_d;
            max_q      <= max_d;
            span_q     <= span_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            conv_cnt_q <= conv_cnt_d;
            value_q    <= value_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            resultat_q <= resultat_d;
            erreur_q   <= erreur_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        // Free-running in every state so the press timing feeds the draw.
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        min_d      = min_q;
        max_d      = max_q;
        span_d     = span_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        conv_cnt_d = conv_cnt_q;
        value_d    = value_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        resultat_d = resultat_q;
        erreur_d   = erreur_q;

        case (state_q)
            StIdle, StDone: begin
                if (rise) begin
                    min_d    = min_de;
                    max_d    = max_de;
                    span_d   = max_de - min_de + 7'd1;
                    erreur_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRoll;
                end
            end
            StRoll: begin
                if (cnt_q == CntLast) begin
                    sample_d = lfsr_q[7:0];
                    state_d  = StReduce;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReduce: begin
                if (min_q > max_q) begin
                    value_d    = min_q;
                    bin_d      = min_q;
                    bcd_d      = '0;
                    conv_cnt_d = '0;
                    erreur_d   = 1'b1;
                    state_d    = StConv;
                end else if (sample_q >= {1'b0, span_q}) begin
                    sample_d = sample_q - {1'b0, span_q};
                end else begin
                    // sample < span <= 100 here, so the top bit is zero.
                    value_d    = min_q + sample_q[6:0];
                    bin_d      = min_q + sample_q[6:0];
                    bcd_d      = '0;
                    conv_cnt_d = '0;
                    state_d    = StConv;
                end
            end
            StConv: begin
                // Steps 0..6 shift one bit each; step 7 publishes the result.
                if (conv_cnt_q == 3'd7) begin
                    resultat_d = value_q;
                    state_d    = StDone;
                end else begin
                    bcd_d      = {bcd_adj[10:0], bin_q[6]};
                    bin_d      = {bin_q[5:0], 1'b0};
                    conv_cnt_d = conv_cnt_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign resultat = resultat_q;
    assign erreur   = erreur_q;
    assign valide   = (state_q == StDone);
    assign occupe   = (state_q == StRoll) || (state_q == StReduce) || (state_q == StConv);

    always_comb begin
        hex100 = SegBlank;
        hex10  = SegBlank;
        hex1   = SegBlank;
        case (state_q)
            StDone: begin
                hex1 = seg7(bcd_q[3:0]);
                if (bcd_q[11:8] != 4'd0) begin
                    hex100 = seg7(bcd_q[11:8]);
                end
                if ((bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0)) begin
                    hex10 = seg7(bcd_q[7:4]);
                end
            end
            StRoll, StReduce, StConv: begin
`ifdef LANCER_DE_ANIM_EN
                hex100 = seg7(mod10(lfsr_q[3:0]));
                hex10  = seg7(mod10(lfsr_q[7:4]));
                hex1   = seg7(mod10(lfsr_q[11:8]));
`else
                hex100 = SegDash;
                hex10  = SegDash;
                hex1   = SegDash;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lancer_de.sv
// Self-checking bench for lancer_de: LFSR/reduction model feeds a scoreboard checked on valide rise.

module tb_lancer_de;

    localparam int unsigned Rc   = 10;
    localparam logic [15:0] Seed = 16'hACE1;

    logic       clk;
    logic       rst;
    logic       lancer;
    logic [6:0] min_de;
    logic [6:0] max_de;
    logic [6:0] resultat;
    logic       valide;
    logic       occupe;
    logic       erreur;
    logic [6:0] hex100;
    logic [6:0] hex10;
    logic [6:0] hex1;

    typedef struct {
        int res;
        bit err;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rise_count = 0;
    int          last_res = 0;
    logic [15:0] m_lfsr;
    logic        valide_prev = 1'b0;

    lancer_de #(
        .ROLL_CYCLES(Rc),
        .LFSR_SEED  (Seed)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lancer  (lancer),
        .min_de  (min_de),
        .max_de  (max_de),
        .resultat(resultat),
        .valide  (valide),
        .occupe  (occupe),
        .erreur  (erreur),
        .hex100  (hex100),
        .hex10   (hex10),
        .hex1    (hex1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Active-high a..g patterns, inverted for the active-low display.
    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] hi [10];
        hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return ~hi[d];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_lfsr <= Seed;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    // Scoreboard consumer: every valide rise must match the oldest expected roll.
    always @(negedge clk) begin
        if (valide && !valide_prev) begin
            rise_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valide: resultat=%0d with no pending roll", resultat);
            end else begin
                exp_t e;
                int h, t, o;
                logic [6:0] e100, e10, e1;
                e = sb.pop_front();
                h = e.res / 100;
                t = (e.res / 10) % 10;
                o = e.res % 10;
                e100 = (h == 0) ? 7'h7F : exp_seg(h);
                e10  = (h == 0 && t == 0) ? 7'h7F : exp_seg(t);
                e1   = exp_seg(o);
                if (resultat !== 7'(e.res) || erreur !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL roll_result: got res=%0d err=%0b cyc=%0d, want res=%0d err=%0b cyc=%0d",
                             resultat, erreur, cyc, e.res, e.err, e.cyc);
                end
                checks++;
                if (hex100 !== e100 || hex10 !== e10 || hex1 !== e1) begin
                    errors++;
                    $display("FAIL roll_display: got %h %h %h, want %h %h %h",
                             hex100, hex10, hex1, e100, e10, e1);
                end
            end
        end
        valide_prev <= valide;
    end

    // Drives one request edge and pushes the modelled outcome; returns one cycle later.
    task automatic request(input int mn, input int mx);
        logic [15:0] s;
        int sample, span, q;
        exp_t e;
        @(negedge clk);
        min_de = 7'(mn);
        max_de = 7'(mx);
        lancer = 1'b1;
        s = m_lfsr;
        for (int i = 0; i < int'(Rc); i++) s = lfsr_step(s);
        sample = int'(s[7:0]);
        if (mn > mx) begin
            e.res = mn;
            e.err = 1'b1;
            q = 0;
        end else begin
            span  = mx - mn + 1;
            q     = sample / span;
            e.res = mn + sample % span;
            e.err = 1'b0;
        end
        e.cyc = cyc + 1 + int'(Rc) + (q + 1) + 7 + 1;
        sb.push_back(e);
        last_res = e.res;
        @(negedge clk);
        lancer = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sb.size() == 0 && occupe == 1'b0) break;
            @(negedge clk);
        end
        if (i == budget) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout: pending=%0d occupe=%0b after %0d cycles",
                     sb.size(), occupe, budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (resultat !== 7'd0 || valide !== 1'b0 || occupe !== 1'b0 || erreur !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: res=%0d v=%0b o=%0b e=%0b, want 0 0 0 0",
                     resultat, valide, occupe, erreur);
        end
        checks++;
        if (hex100 !== 7'h7F || hex10 !== 7'h7F || hex1 !== 7'h7F) begin
            errors++;
            $display("FAIL reset_display: got %h %h %h, want 7f 7f 7f", hex100, hex10, hex1);
        end
    endtask

    task automatic test_d6();
        request(1, 6);
        checks++;
        if (occupe !== 1'b1 || valide !== 1'b0) begin
            errors++;
            $display("FAIL d6_occupe_rise: occupe=%0b valide=%0b, want 1 0", occupe, valide);
        end
        checks++;
`ifdef LANCER_DE_ANIM_EN
        if (hex100 === 7'h7F || hex10 === 7'h7F || hex1 === 7'h7F ||
            hex100 === 7'h3F || hex10 === 7'h3F || hex1 === 7'h3F) begin
            errors++;
            $display("FAIL d6_roll_anim: got %h %h %h, want lfsr digits", hex100, hex10, hex1);
        end
`else
        if (hex100 !== 7'h3F || hex10 !== 7'h3F || hex1 !== 7'h3F) begin
            errors++;
            $display("FAIL d6_roll_dash: got %h %h %h, want 3f 3f 3f", hex100, hex10, hex1);
        end
`endif
        wait_done(Rc + 300);
        checks++;
        if (resultat < 7'd1 || resultat > 7'd6 || hex100 !== 7'h7F || hex10 !== 7'h7F) begin
            errors++;
            $display("FAIL d6_range: res=%0d hex100=%h hex10=%h, want 1..6 7f 7f",
                     resultat, hex100, hex10);
        end
    endtask

    task automatic test_d100();
        int bad = 0;
        for (int n = 0; n < 1000; n++) begin
            request(1, 100);
            wait_done(Rc + 300);
            checks++;
            if (resultat < 7'd1 || resultat > 7'd100) begin
                errors++;
                bad++;
                if (bad < 5) $display("FAIL d100_range: res=%0d, want 1..100", resultat);
            end
        end
        // Fixed bounds hit the three-digit display and the span=1 worst case.
        request(100, 100);
        wait_done(Rc + 300);
        request(1, 1);
        wait_done(Rc + 300);
        request(42, 57);
        wait_done(Rc + 300);
    endtask

    task automatic test_busy();
        int r0 = rise_count;
        request(1, 20);
        lancer = 1'b1;
        max_de = 7'd3;
        @(negedge clk);
        lancer = 1'b0;
        repeat (Rc - 2) @(negedge clk);
        lancer = 1'b1;
        @(negedge clk);
        lancer = 1'b0;
        checks++;
        if (occupe !== 1'b1) begin
            errors++;
            $display("FAIL busy_still_occupe: occupe=%0b, want 1", occupe);
        end
        wait_done(Rc + 300);
        repeat (40) @(negedge clk);
        checks++;
        if (rise_count - r0 != 1 || occupe !== 1'b0) begin
            errors++;
            $display("FAIL busy_single_valide: rises=%0d occupe=%0b, want 1 0",
                     rise_count - r0, occupe);
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        request(3, 9);
        wait_done(Rc + 300);
        prev = last_res;
        request(1, 12);
        checks++;
        if (valide !== 1'b0 || occupe !== 1'b1 || resultat !== 7'(prev)) begin
            errors++;
            $display("FAIL b2b_hold: v=%0b o=%0b res=%0d, want 0 1 %0d", valide, occupe, resultat, prev);
        end
        wait_done(Rc + 300);
    endtask

    task automatic test_error();
        request(8, 4);
        wait_done(Rc + 300);
        checks++;
        if (erreur !== 1'b1 || resultat !== 7'd8 || valide !== 1'b1) begin
            errors++;
            $display("FAIL error_path: e=%0b res=%0d v=%0b, want 1 8 1", erreur, resultat, valide);
        end
        request(1, 6);
        checks++;
        if (erreur !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: erreur=%0b, want 0", erreur);
        end
        wait_done(Rc + 300);
    endtask

    task automatic test_midroll_reset();
        request(1, 6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        checks++;
        if (resultat !== 7'd0 || valide !== 1'b0 || occupe !== 1'b0 || erreur !== 1'b0 ||
            hex100 !== 7'h7F || hex10 !== 7'h7F || hex1 !== 7'h7F) begin
            errors++;
            $display("FAIL midroll_reset: res=%0d v=%0b o=%0b e=%0b hex=%h %h %h, want reset",
                     resultat, valide, occupe, erreur, hex100, hex10, hex1);
        end
        rst = 1'b0;
        request(2, 11);
        wait_done(Rc + 300);
        // Request edge coinciding with reset in DONE: reset must win.
        @(negedge clk);
        rst    = 1'b1;
        lancer = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        lancer = 1'b0;
        checks++;
        if (occupe !== 1'b0 || valide !== 1'b0 || resultat !== 7'd0) begin
            errors++;
            $display("FAIL reset_wins: o=%0b v=%0b res=%0d, want 0 0 0", occupe, valide, resultat);
        end
        request(5, 10);
        wait_done(Rc + 300);
    endtask

    initial begin
        rst    = 1'b1;
        lancer = 1'b0;
        min_de = 7'd1;
        max_de = 7'd6;
        test_reset();
        test_d6();
        test_d100();
        test_busy();
        test_back_to_back();
        test_error();
        test_midroll_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d rolls never completed, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
